// File: rtl/fpm_pkg.sv
// Shared constants, FSM state type and normalized-result record for the
// multiplier back end, plus the normalize function used by the CPA stage.
package fpm_pkg;

  localparam int PROD_W = 48;
  localparam int MANT_W = 24;

  typedef enum logic [1:0] {IDLE, ADD, NORM, HOLD} cpa_state_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic              g;
    logic              r;
    logic              s;
    logic              exp_inc;
  } fpm_norm_t;

  // A zero product takes the P[MSB]=0 path and yields an all-zero record.
  function automatic fpm_norm_t normalize(input logic [PROD_W-1:0] p);
    fpm_norm_t n;
    if (p[PROD_W-1]) begin
      n.mant    = p[PROD_W-1 -: MANT_W];
      n.g       = p[PROD_W-MANT_W-1];
      n.r       = p[PROD_W-MANT_W-2];
      n.s       = |p[PROD_W-MANT_W-3:0];
      n.exp_inc = 1'b1;
    end else begin
      n.mant    = p[PROD_W-2 -: MANT_W];
      n.g       = p[PROD_W-MANT_W-2];
      n.r       = p[PROD_W-MANT_W-3];
      n.s       = |p[PROD_W-MANT_W-4:0];
      n.exp_inc = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/fpm_cpa_normalize_if.sv
// Operand and result handshake bundle between the Booth reduction tree,
// the CPA/normalize stage and the rounder.
interface fpm_cpa_normalize_if;
  import fpm_pkg::*;

  // Both sides use valid/ready: a transfer happens at a rising edge where
  // valid and ready are both 1; valid must not depend on ready, and the
  // producer holds data stable while valid is high and ready is low.
  logic                in_valid;
  logic                in_ready;
  logic [PROD_W-1:0]   sum_row;
  logic [PROD_W-2:0]   carry_row;
  logic                out_valid;
  logic                out_ready;
  logic [MANT_W-1:0]   mant_out;
  logic                guard_bit;
  logic                round_bit;
  logic                sticky_bit;
  logic                exp_inc;

  modport master (
    output in_valid, sum_row, carry_row, out_ready,
    input  in_ready, out_valid, mant_out, guard_bit, round_bit, sticky_bit, exp_inc
  );

  modport slave (
    input  in_valid, sum_row, carry_row, out_ready,
    output in_ready, out_valid, mant_out, guard_bit, round_bit, sticky_bit, exp_inc
  );

endinterface

// File: rtl/fpm_cpa_chunk.sv
// One slice of the chunked carry-propagate adder: CHUNK_W-bit add with
// carry in and carry out.
module fpm_cpa_chunk #(
  parameter int CHUNK_W = 12
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};

endmodule

// File: rtl/fpm_cpa_normalize.sv
// Resolves the carry-save product rows with a single time-shared adder slice,
// then normalizes the 48-bit product to a 24-bit significand plus G/R/S.
module fpm_cpa_normalize
  import fpm_pkg::*;
#(
  parameter int CHUNK_W = 12
) (
  input  logic                 clk,
  input  logic                 n_rst,
  fpm_cpa_normalize_if.slave   bus,
  output cpa_state_t           dbg_state
);

  localparam int NCH   = PROD_W / CHUNK_W;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  cpa_state_t          state_q, state_d;
  logic [PROD_W-1:0]   sum_q;
  logic [PROD_W-1:0]   addend_q;
  logic [PROD_W-1:0]   res_q;
  logic [IDX_W-1:0]    chunk_idx;
  logic                cin_q;
  fpm_norm_t           norm_q;

  logic [CHUNK_W-1:0]  a_slice;
  logic [CHUNK_W-1:0]  b_slice;
  logic [CHUNK_W-1:0]  s_slice;
  logic                s_cout;

  assign a_slice = sum_q[chunk_idx*CHUNK_W +: CHUNK_W];
  assign b_slice = addend_q[chunk_idx*CHUNK_W +: CHUNK_W];

  fpm_cpa_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (cin_q),
    .sum  (s_slice),
    .cout (s_cout)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = ADD;
      end
      ADD:  if (chunk_idx == LAST_IDX) state_d = NORM;
      NORM: state_d = HOLD;
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The carry row is pre-shifted into its true weight at capture, so the
  // adder only ever sees two aligned PROD_W-bit operands.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sum_q     <= '0;
      addend_q  <= '0;
      res_q     <= '0;
      chunk_idx <= '0;
      cin_q     <= 1'b0;
      norm_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          sum_q     <= bus.sum_row;
          addend_q  <= {bus.carry_row, 1'b0};
          chunk_idx <= '0;
          cin_q     <= 1'b0;
        end
        ADD: begin
          res_q[chunk_idx*CHUNK_W +: CHUNK_W] <= s_slice;
          cin_q     <= s_cout;
          chunk_idx <= chunk_idx + 1'b1;
        end
        NORM:    norm_q <= normalize(res_q);
        default: ;
      endcase
    end
  end

  assign bus.mant_out   = norm_q.mant;
  assign bus.guard_bit  = norm_q.g;
  assign bus.round_bit  = norm_q.r;
  assign bus.sticky_bit = norm_q.s;
  assign bus.exp_inc    = norm_q.exp_inc;
  assign dbg_state      = state_q;

endmodule
